// File: rtl/reader_pkg.sv
// rtl/reader_pkg.sv - shared types, AXI constants and helpers for the burst reader
package reader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [1:0] RESP_OKAY  = 2'b00;
  localparam logic [1:0] BURST_INCR = 2'b01;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/reader_ar_issuer.sv
// rtl/reader_ar_issuer.sv - AR address generator with issued count and outstanding-burst credit
module reader_ar_issuer
  import reader_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int NB_W    = 16,
  parameter int MAX_OUT = 4,
  parameter int OUT_W   = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [ADDR_W-1:0] base,
  input  logic [ADDR_W-1:0] stride,
  input  logic [NB_W-1:0]   num_bursts,
  input  logic              issue_en,
  input  logic              burst_done,
  input  logic              arready,
  output logic [ADDR_W-1:0] araddr,
  output logic              arvalid,
  output logic [OUT_W-1:0]  outstanding,
  output logic              all_issued
);

  logic [NB_W-1:0]  issued;
  logic [NB_W-1:0]  issued_next;
  logic [OUT_W-1:0] outstanding_next;
  logic             ar_fire;

  // A simultaneous AR handshake and burst completion cancel out.
  always_comb begin
    ar_fire          = arvalid && arready;
    issued_next      = issued + NB_W'(ar_fire);
    outstanding_next = outstanding;
    if (ar_fire && !burst_done) begin
      outstanding_next = outstanding + OUT_W'(1);
    end else if (!ar_fire && burst_done && (outstanding != '0)) begin
      outstanding_next = outstanding - OUT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      araddr      <= '0;
      arvalid     <= 1'b0;
      issued      <= '0;
      outstanding <= '0;
    end else if (load) begin
      araddr      <= base;
      arvalid     <= 1'b0;
      issued      <= '0;
      outstanding <= '0;
    end else begin
      issued      <= issued_next;
      outstanding <= outstanding_next;
      if (ar_fire) araddr <= araddr + stride;
      // A pending request is held untouched until the slave takes it.
      if (!arvalid || ar_fire) begin
        arvalid <= issue_en && (issued_next < num_bursts) &&
                   (outstanding_next < OUT_W'(MAX_OUT));
      end
    end
  end

  assign all_issued = (issued == num_bursts);

endmodule

// File: rtl/reader_burst_master.sv
// rtl/reader_burst_master.sv - AXI4 read burst master gathering strided bursts onto a data stream
module reader_burst_master
  import reader_pkg::*;
#(
  parameter int C_M_AXI_ADDR_WIDTH = 32,
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int C_M_AXI_BURST_LEN  = 16,
  parameter int C_MAX_OUTSTANDING  = 4,
  parameter int C_NUM_BURSTS_WIDTH = 16
) (
  input  logic                          ACLK,
  input  logic                          ARESET,
  input  logic                          INIT_AXI_TXN,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0] CFG_BASE_ADDR,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0] CFG_STRIDE,
  input  logic [C_NUM_BURSTS_WIDTH-1:0] CFG_NUM_BURSTS,
  output logic                          TXN_DONE,
  output logic                          ERROR,
  output logic                          BUSY,
  output logic [C_M_AXI_ADDR_WIDTH-1:0] M_AXI_ARADDR,
  output logic [7:0]                    M_AXI_ARLEN,
  output logic [2:0]                    M_AXI_ARSIZE,
  output logic [1:0]                    M_AXI_ARBURST,
  output logic                          M_AXI_ARVALID,
  input  logic                          M_AXI_ARREADY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0] M_AXI_RDATA,
  input  logic [1:0]                    M_AXI_RRESP,
  input  logic                          M_AXI_RLAST,
  input  logic                          M_AXI_RVALID,
  output logic                          M_AXI_RREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0] DOUT_TDATA,
  output logic                          DOUT_TVALID,
  input  logic                          DOUT_TREADY,
  output logic                          DOUT_TLAST
);

  localparam int AW          = C_M_AXI_ADDR_WIDTH;
  localparam int NW          = C_NUM_BURSTS_WIDTH;
  localparam int BURST_BYTES = C_M_AXI_BURST_LEN * C_M_AXI_DATA_WIDTH / 8;
  localparam int BEAT_W      = clog2(C_M_AXI_BURST_LEN + 1);
  localparam int OUT_W       = clog2(C_MAX_OUTSTANDING + 1);

  localparam logic [AW-1:0]     BURST_BYTES_A = AW'(BURST_BYTES);
  localparam logic [BEAT_W-1:0] LAST_BEAT     = BEAT_W'(C_M_AXI_BURST_LEN - 1);

  state_t            state;
  logic              init_q, init_qq, check_q;
  logic              busy, txn_done, error;
  logic [AW-1:0]     cfg_base, cfg_stride;
  logic [NW-1:0]     cfg_num;
  logic [BEAT_W-1:0] beat_cnt;
  logic [NW-1:0]     bursts_completed;
  logic [OUT_W-1:0]  outstanding;
  logic              all_issued;
  logic              start_pulse, accept, cfg_bad, go;
  logic              r_fire, last_beat, burst_done, beat_err;

  assign start_pulse = init_q && !init_qq;
  assign accept      = start_pulse && !check_q && ((state == IDLE) || (state == DONE));
  // Burst-aligned base and stride keep every burst inside one 4KB page.
  assign cfg_bad     = ((cfg_base % BURST_BYTES_A) != '0) || ((cfg_stride % BURST_BYTES_A) != '0);
  assign go          = check_q && !cfg_bad && (cfg_num != '0);

  assign M_AXI_RREADY = DOUT_TREADY && busy;
  assign DOUT_TVALID  = M_AXI_RVALID && busy;
  assign DOUT_TDATA   = M_AXI_RDATA;
  assign DOUT_TLAST   = M_AXI_RLAST && (bursts_completed == (cfg_num - NW'(1)));

  assign r_fire     = M_AXI_RVALID && M_AXI_RREADY;
  assign last_beat  = (beat_cnt == LAST_BEAT);
  // A missing RLAST still closes the burst at its final beat so the job can drain.
  assign burst_done = r_fire && (M_AXI_RLAST || last_beat);
  assign beat_err   = r_fire && ((M_AXI_RRESP != RESP_OKAY) || (M_AXI_RLAST != last_beat));

  reader_ar_issuer #(
    .ADDR_W  (AW),
    .NB_W    (NW),
    .MAX_OUT (C_MAX_OUTSTANDING),
    .OUT_W   (OUT_W)
  ) u_ar_issuer (
    .clk         (ACLK),
    .rst         (ARESET),
    .load        (accept),
    .base        (CFG_BASE_ADDR),
    .stride      (cfg_stride),
    .num_bursts  (cfg_num),
    .issue_en    ((state == RUN) || go),
    .burst_done  (burst_done),
    .arready     (M_AXI_ARREADY),
    .araddr      (M_AXI_ARADDR),
    .arvalid     (M_AXI_ARVALID),
    .outstanding (outstanding),
    .all_issued  (all_issued)
  );

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state            <= IDLE;
      init_q           <= 1'b0;
      init_qq          <= 1'b0;
      check_q          <= 1'b0;
      busy             <= 1'b0;
      txn_done         <= 1'b0;
      error            <= 1'b0;
      cfg_base         <= '0;
      cfg_stride       <= '0;
      cfg_num          <= '0;
      beat_cnt         <= '0;
      bursts_completed <= '0;
    end else begin
      init_q  <= INIT_AXI_TXN;
      init_qq <= init_q;
      check_q <= accept;
      if (r_fire) beat_cnt <= burst_done ? '0 : beat_cnt + BEAT_W'(1);
      if (burst_done) bursts_completed <= bursts_completed + NW'(1);
      if (beat_err) error <= 1'b1;
      unique case (state)
        IDLE, DONE: begin
          if (accept) begin
            state            <= IDLE;
            cfg_base         <= CFG_BASE_ADDR;
            cfg_stride       <= CFG_STRIDE;
            cfg_num          <= CFG_NUM_BURSTS;
            txn_done         <= 1'b0;
            error            <= 1'b0;
            beat_cnt         <= '0;
            bursts_completed <= '0;
          end else if (check_q) begin
            if (cfg_bad) begin
              state    <= DONE;
              txn_done <= 1'b1;
              error    <= 1'b1;
            end else if (cfg_num == '0) begin
              state    <= DONE;
              txn_done <= 1'b1;
            end else begin
              state <= RUN;
              busy  <= 1'b1;
            end
          end
        end
        RUN: begin
          if (all_issued) state <= DRAIN;
        end
        DRAIN: begin
          if (outstanding == '0) begin
            state    <= DONE;
            busy     <= 1'b0;
            txn_done <= 1'b1;
          end
        end
      endcase
    end
  end

  assign TXN_DONE      = txn_done;
  assign ERROR         = error;
  assign BUSY          = busy;
  assign M_AXI_ARLEN   = 8'(C_M_AXI_BURST_LEN - 1);
  assign M_AXI_ARSIZE  = 3'(clog2(C_M_AXI_DATA_WIDTH / 8));
  assign M_AXI_ARBURST = BURST_INCR;

endmodule
